// File: rtl/seven_seg_scanner.sv
// Six-digit common-anode seven-segment scanner with frame-synchronous BCD capture.
// Optional define BLINK_SET_EN blinks the hours/minutes digits while set_time is low.
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       master_clock,
  input  logic       reset_n,
  input  logic [7:0] hours_bcd,
  input  logic [7:0] minutes_bcd,
  input  logic [7:0] seconds_bcd,
  input  logic       set_time,
  output logic [5:0] anode,
  output logic [6:0] segments,
  output logic       dp
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = 3;
  localparam int unsigned SW = 24;

  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] shadow_q, shadow_d;
  logic [5:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          slot_end, frame_end, hide_hm;
  logic [3:0]    nibble;
  logic [6:0]    decoded;

  // Slot/frame timing and tear-free capture of the whole time value.
  always_comb begin
    slot_end  = (presc_q == PW'(REFRESH_DIV - 1));
    frame_end = slot_end && (idx_q == IW'(5));
    presc_d   = slot_end ? '0 : presc_q + PW'(1);
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IW'(5)) ? '0 : idx_q + IW'(1);
    end
    shadow_d = frame_end ? {hours_bcd, minutes_bcd, seconds_bcd} : shadow_q;
  end

`ifdef BLINK_SET_EN
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_end) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge master_clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign hide_hm = ~set_time & blink_q;
`else
  logic unused_blink;
  assign unused_blink = set_time | (BLINK_FRAMES == 0);
  assign hide_hm      = 1'b0;
`endif

  // Digit select, decode and slot-phase output shaping.
  always_comb begin
    case (idx_q)
      IW'(1):  nibble = shadow_q[7:4];
      IW'(2):  nibble = shadow_q[11:8];
      IW'(3):  nibble = shadow_q[15:12];
      IW'(4):  nibble = shadow_q[19:16];
      IW'(5):  nibble = shadow_q[23:20];
      default: nibble = shadow_q[3:0];
    endcase

    case (nibble)
      4'd0:    decoded = 7'b1000000;
      4'd1:    decoded = 7'b1111001;
      4'd2:    decoded = 7'b0100100;
      4'd3:    decoded = 7'b0110000;
      4'd4:    decoded = 7'b0011001;
      4'd5:    decoded = 7'b0010010;
      4'd6:    decoded = 7'b0000010;
      4'd7:    decoded = 7'b1111000;
      4'd8:    decoded = 7'b0000000;
      4'd9:    decoded = 7'b0010000;
      default: decoded = 7'b0111111;
    endcase

    anode_d = 6'b111111;
    seg_d   = 7'b1111111;
    dp_d    = 1'b1;
    if (32'(presc_q) >= BLANK_CYCLES) begin
      seg_d = decoded;
      if (hide_hm && (idx_q >= IW'(2))) begin
        anode_d = 6'b111111;
      end else begin
        anode_d = ~(6'(1) << idx_q);
        dp_d    = ~((idx_q == IW'(2)) || (idx_q == IW'(4)));
      end
    end
  end

  always_ff @(posedge master_clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      anode_q  <= 6'b111111;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign anode    = anode_q;
  assign segments = seg_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner (REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2).
module tb_seven_seg_scanner;

  localparam int unsigned RD = 8;
  localparam int unsigned BC = 2;
  localparam int unsigned BF = 2;
`ifdef BLINK_SET_EN
  localparam logic [5:0] BLINK_MASK = 6'b111100;
`else
  localparam logic [5:0] BLINK_MASK = 6'b000000;
`endif

  logic       master_clock = 1'b0;
  logic       reset_n      = 1'b0;
  logic [7:0] hours_bcd    = 8'h12;
  logic [7:0] minutes_bcd  = 8'h34;
  logic [7:0] seconds_bcd  = 8'h56;
  logic       set_time     = 1'b1;
  logic [5:0] anode;
  logic [6:0] segments;
  logic       dp;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] seg_tab [16];

  seven_seg_scanner #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .master_clock(master_clock),
    .reset_n     (reset_n),
    .hours_bcd   (hours_bcd),
    .minutes_bcd (minutes_bcd),
    .seconds_bcd (seconds_bcd),
    .set_time    (set_time),
    .anode       (anode),
    .segments    (segments),
    .dp          (dp)
  );

  always #5 master_clock = ~master_clock;

  // Checks consecutive slots, starting aligned to slot `first` prescaler 0.
  task automatic check_slots(input int first, input int last, input logic [23:0] shown,
                             input logic [5:0] mask, input string tag);
    logic [5:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [3:0] nib;
    for (int s = first; s <= last; s++) begin
      for (int p = 0; p < int'(RD); p++) begin
        @(negedge master_clock);
        exp_an  = 6'b111111;
        exp_seg = 7'b1111111;
        exp_dp  = 1'b1;
        if (p >= int'(BC)) begin
          nib     = shown[4*s +: 4];
          exp_seg = seg_tab[nib];
          if (!mask[s]) begin
            exp_an = ~(6'(1) << s);
            exp_dp = !((s == 2) || (s == 4));
          end
        end
        n_tests++;
        if ({anode, segments, dp} !== {exp_an, exp_seg, exp_dp}) begin
          n_fail++;
          $display("FAIL %s slot%0d p%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                   tag, s, p, anode, segments, dp, exp_an, exp_seg, exp_dp);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge master_clock);
    n_tests++;
    if ({anode, segments, dp} !== {6'b111111, 7'b1111111, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got an=%b seg=%b dp=%b, want 111111 1111111 1",
               anode, segments, dp);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_first_frames();
    check_slots(0, 5, 24'h000000, 6'b0, "frame0_zero");
    check_slots(0, 5, 24'h123456, 6'b0, "frame1_123456");
  endtask

  task automatic test_midframe_capture();
    check_slots(0, 1, 24'h123456, 6'b0, "frame2_pre");
    seconds_bcd = 8'h57;
    check_slots(2, 5, 24'h123456, 6'b0, "frame2_post");
    check_slots(0, 5, 24'h123457, 6'b0, "frame3_57");
  endtask

  task automatic test_invalid_code();
    minutes_bcd = 8'hA3;
    check_slots(0, 5, 24'h123457, 6'b0, "frame4_old");
    check_slots(0, 5, 24'h12A357, 6'b0, "frame5_dash");
  endtask

  task automatic test_dp();
    int lows = 0;
    int bad_dp = 0;
    int multi = 0;
    int zeros;
    for (int i = 0; i < int'(6 * RD); i++) begin
      @(negedge master_clock);
      zeros = 0;
      for (int b = 0; b < 6; b++) if (anode[b] == 1'b0) zeros++;
      if (zeros > 1) multi++;
      if (dp == 1'b0) begin
        lows++;
        if (anode[2] !== 1'b0 && anode[4] !== 1'b0) bad_dp++;
      end
    end
    n_tests++;
    if (lows != 2 * int'(RD - BC)) begin
      n_fail++;
      $display("FAIL dp_low_count: got %0d, want %0d", lows, 2 * int'(RD - BC));
    end
    n_tests++;
    if (bad_dp != 0) begin
      n_fail++;
      $display("FAIL dp_outside_digit2_4: got %0d cycles, want 0", bad_dp);
    end
    n_tests++;
    if (multi != 0) begin
      n_fail++;
      $display("FAIL anode_multi_low: got %0d cycles, want 0", multi);
    end
  endtask

  task automatic test_reset_midslot();
    check_slots(0, 3, 24'h12A357, 6'b0, "frame7_pre");
    repeat (3) @(negedge master_clock);
    n_tests++;
    if (anode !== 6'b101111) begin
      n_fail++;
      $display("FAIL midslot_lit: got an=%b, want 101111", anode);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({anode, segments, dp} !== {6'b111111, 7'b1111111, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: got an=%b seg=%b dp=%b, want 111111 1111111 1",
               anode, segments, dp);
    end
    @(negedge master_clock);
    reset_n = 1'b1;
    check_slots(0, 5, 24'h000000, 6'b0, "rst_frame0_zero");
    check_slots(0, 5, 24'h12A357, 6'b0, "rst_frame1");
  endtask

  task automatic test_blink();
    reset_n  = 1'b0;
    set_time = 1'b0;
    @(negedge master_clock);
    reset_n = 1'b1;
    check_slots(0, 5, 24'h000000, 6'b0, "blink_f0");
    check_slots(0, 5, 24'h12A357, 6'b0, "blink_f1");
    check_slots(0, 5, 24'h12A357, BLINK_MASK, "blink_f2");
    check_slots(0, 5, 24'h12A357, BLINK_MASK, "blink_f3");
    check_slots(0, 5, 24'h12A357, 6'b0, "blink_f4");
    check_slots(0, 5, 24'h12A357, 6'b0, "blink_f5");
    set_time = 1'b1;
    check_slots(0, 5, 24'h12A357, 6'b0, "blink_f6_run");
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'b0111111;

    test_reset();
    test_first_frames();
    test_midframe_capture();
    test_invalid_code();
    test_dp();
    test_reset_midslot();
    test_blink();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
